// File: rtl/mem_arbiter_if.sv
// Memory port bundle: request strobes and payload toward the memory, completion and read data back.
interface mem_arbiter_if #(
   parameter int unsigned WIDTH = 16
);
   logic             read;
   logic             write;
   logic [1:0]       wmask;
   logic [WIDTH-1:0] address;
   logic [WIDTH-1:0] wdata;
   logic             resp;
   logic [WIDTH-1:0] rdata;

   modport master (output read, write, wmask, address, wdata, input resp, rdata);
   modport slave  (input read, write, wmask, address, wdata, output resp, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (A = fetch, B = data) sharing one memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is B-over-A with A starvation guard.
module mem_arbiter #(
   parameter int unsigned WIDTH        = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  port_a,
   mem_arbiter_if.slave  port_b,
   mem_arbiter_if.master pmem
);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_e;

   typedef struct packed {
      logic             read;
      logic             write;
      logic [1:0]       wmask;
      logic [WIDTH-1:0] address;
      logic [WIDTH-1:0] wdata;
   } req_t;

   state_e state_q, state_d;
   req_t   req_q, req_d;
   logic   req_a, req_b, win_a, grant_a, grant_b;
   logic   resp_a_c, resp_b_c;

   assign req_a   = port_a.read | port_a.write;
   assign req_b   = port_b.read | port_b.write;
   assign grant_a = (state_q == IDLE) & win_a;
   assign grant_b = (state_q == IDLE) & req_b & ~win_a;

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_last_q, rr_last_d;  // 1: last grant went to B

   assign win_a = req_a & (~req_b | rr_last_q);

   always_comb begin
      rr_last_d = rr_last_q;
      if (grant_a)      rr_last_d = 1'b0;
      else if (grant_b) rr_last_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rr_last_q <= 1'b1;
      else       rr_last_q <= rr_last_d;
   end
`else
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             starved;

   assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
   assign win_a   = req_a & (~req_b | starved);

   // Count B grants that passed over a waiting A; saturates at the limit.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_a)                          starve_cnt_d = '0;
      else if (grant_b && req_a && !starved) starve_cnt_d = starve_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) starve_cnt_q <= '0;
      else       starve_cnt_q <= starve_cnt_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_a)      state_d = SERVE_A;
            else if (grant_b) state_d = SERVE_B;
         end
         SERVE_A, SERVE_B: if (pmem.resp) state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   // Capture the winner's request; held untouched for the whole transaction.
   always_comb begin
      req_d = req_q;
      if (grant_a)
         req_d = '{read: port_a.read, write: port_a.write, wmask: port_a.wmask,
                   address: port_a.address, wdata: port_a.wdata};
      else if (grant_b)
         req_d = '{read: port_b.read, write: port_b.write, wmask: port_b.wmask,
                   address: port_b.address, wdata: port_b.wdata};
   end

   // Read+write on one port resolves to a write.
   always_comb begin
      resp_a_c     = (state_q == SERVE_A) & pmem.resp;
      resp_b_c     = (state_q == SERVE_B) & pmem.resp;
      pmem.read    = (state_q != IDLE) & req_q.read & ~req_q.write;
      pmem.write   = (state_q != IDLE) & req_q.write;
      pmem.wmask   = req_q.wmask;
      pmem.address = req_q.address;
      pmem.wdata   = req_q.wdata;
      port_a.resp  = resp_a_c;
      port_b.resp  = resp_b_c;
      port_a.rdata = resp_a_c ? pmem.rdata : '0;
      port_b.rdata = resp_b_c ? pmem.rdata : '0;
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked against a transaction-level model.
module tb_mem_arbiter;
   localparam int unsigned W     = 16;
   localparam int          LIMIT = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.WIDTH(W)) a_bus ();
   mem_arbiter_if #(.WIDTH(W)) b_bus ();
   mem_arbiter_if #(.WIDTH(W)) pm_bus ();

   mem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .port_a(a_bus),
      .port_b(b_bus),
      .pmem  (pm_bus)
   );

   typedef struct {
      logic         rd;
      logic         wr;
      logic [1:0]   wm;
      logic [W-1:0] ad;
      logic [W-1:0] wd;
   } txn_t;

   // model: owner 0 = none, 1 = A, 2 = B
   int           owner, starve, rr_last;
   txn_t         cur;
   int           grants[$];
   int           resp_port[$];
   logic [W-1:0] resp_data[$];
   int           exp_q[$];
   int           n_cmp, n_bad;
   int           lat, wcnt, mode;
   bit           rand_lat, stray_en, use_fixed, a_done, b_done;
   logic [W-1:0] fixed_rdata;

   task automatic chk1(string tag, logic obs, logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chki(string tag, int obs, int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_grants(string tag);
      chki({tag, "_count"}, grants.size() >= exp_q.size() ? exp_q.size() : grants.size(), exp_q.size());
      foreach (exp_q[i])
         chki($sformatf("%s_grant%0d", tag, i), i < grants.size() ? grants[i] : -1, exp_q[i]);
   endtask

   task automatic clear_logs();
      grants.delete();
      resp_port.delete();
      resp_data.delete();
   endtask

   task automatic rand_req(output logic rd, output logic wr, output logic [1:0] wm,
                           output logic [W-1:0] ad, output logic [W-1:0] wd);
      int k;
      k  = int'($urandom_range(0, 3));
      rd = (k == 1) || (k == 3);
      wr = (k == 2) || (k == 3);
      wm = 2'($urandom);
      ad = W'($urandom);
      wd = W'($urandom);
   endtask

   // One clock: check this cycle against the model, advance the model over the edge, drive next cycle.
   task automatic tick();
      bit           serving, ea, eb, ra, rb;
      int           win;
      logic [W-1:0] pr;
      #1;
      if (reset) begin
         owner = 0; starve = 0; rr_last = 2;
      end
      serving = (owner != 0);
      pr      = pm_bus.rdata;
      ea      = (owner == 1) && (pm_bus.resp === 1'b1);
      eb      = (owner == 2) && (pm_bus.resp === 1'b1);
      chk1("pmem_read",  pm_bus.read,  serving && cur.rd && !cur.wr);
      chk1("pmem_write", pm_bus.write, serving && cur.wr);
      if (serving) begin
         chkw("pmem_address", pm_bus.address, cur.ad);
         chkw("pmem_wdata",   pm_bus.wdata,   cur.wd);
         chkw("pmem_wmask",   W'(pm_bus.wmask), W'(cur.wm));
      end else if (reset) begin
         chkw("rst_address", pm_bus.address, '0);
         chkw("rst_wdata",   pm_bus.wdata,   '0);
         chkw("rst_wmask",   W'(pm_bus.wmask), '0);
      end
      chk1("a_resp",  a_bus.resp,  ea);
      chk1("b_resp",  b_bus.resp,  eb);
      chkw("a_rdata", a_bus.rdata, ea ? pr : '0);
      chkw("b_rdata", b_bus.rdata, eb ? pr : '0);
      a_done = ea;
      b_done = eb;
      if (ea) begin resp_port.push_back(1); resp_data.push_back(pr); end
      if (eb) begin resp_port.push_back(2); resp_data.push_back(pr); end

      ra = a_bus.read || a_bus.write;
      rb = b_bus.read || b_bus.write;
      if (reset) begin
         owner = 0;
      end else if (owner != 0) begin
         if (pm_bus.resp === 1'b1) owner = 0;
      end else if (ra || rb) begin
`ifdef ARB_ROUND_ROBIN_EN
         win     = (ra && rb) ? ((rr_last == 2) ? 1 : 2) : (ra ? 1 : 2);
         rr_last = win;
`else
         win = (ra && rb) ? ((starve >= LIMIT) ? 1 : 2) : (ra ? 1 : 2);
         if (win == 1)                 starve = 0;
         else if (ra && starve < LIMIT) starve++;
`endif
         owner  = win;
         cur.rd = (win == 1) ? a_bus.read    : b_bus.read;
         cur.wr = (win == 1) ? a_bus.write   : b_bus.write;
         cur.wm = (win == 1) ? a_bus.wmask   : b_bus.wmask;
         cur.ad = (win == 1) ? a_bus.address : b_bus.address;
         cur.wd = (win == 1) ? a_bus.wdata   : b_bus.wdata;
         grants.push_back(win);
      end

      @(negedge clk);
      // memory responder
      if (pm_bus.read || pm_bus.write) begin
         if (rand_lat && wcnt == 0) lat = int'($urandom_range(1, 4));
         wcnt++;
         pm_bus.resp  = (wcnt >= lat);
         pm_bus.rdata = (use_fixed && wcnt >= lat) ? fixed_rdata : W'($urandom);
         if (wcnt >= lat) wcnt = 0;
      end else begin
         wcnt         = 0;
         pm_bus.resp  = stray_en && ($urandom_range(0, 3) == 0);
         pm_bus.rdata = W'($urandom);
      end
      // requesters
      if (mode == 0) begin
         if (a_done) begin a_bus.read = 1'b0; a_bus.write = 1'b0; end
         if (b_done) begin b_bus.read = 1'b0; b_bus.write = 1'b0; end
      end else if (mode == 2) begin
         if (a_done || $urandom_range(0, 7) == 0)
            rand_req(a_bus.read, a_bus.write, a_bus.wmask, a_bus.address, a_bus.wdata);
         if (b_done || $urandom_range(0, 7) == 0)
            rand_req(b_bus.read, b_bus.write, b_bus.wmask, b_bus.address, b_bus.wdata);
      end
   endtask

   task automatic wait_resps(string tag, int n, int budget);
      int k;
      k = 0;
      while (resp_port.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk1({tag, "_resp_in_time"}, 1'(resp_port.size() >= n), 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      owner = 0; starve = 0; rr_last = 2; wcnt = 0; lat = 3; mode = 0;
      rand_lat = 0; stray_en = 0; use_fixed = 1; fixed_rdata = 16'h5A5A;
      cur = '{default: '0};
      a_bus.read = 0; a_bus.write = 0; a_bus.wmask = 0; a_bus.address = 0; a_bus.wdata = 0;
      b_bus.read = 1; b_bus.write = 0; b_bus.wmask = 0; b_bus.address = 16'h0010; b_bus.wdata = 0;
      pm_bus.resp = 0; pm_bus.rdata = 0;
      reset = 1;
      @(negedge clk);

      // reset held 3 cycles with b_read pending
      repeat (3) tick();
      reset = 0;
      tick();
      chk1("post_rst_strobe", pm_bus.read, 1'b1);
      chkw("post_rst_addr", pm_bus.address, 16'h0010);
      wait_resps("rst_b", 1, 20);
      chki("rst_b_port", resp_port[0], 2);
      chkw("rst_b_rdata", resp_data[0], 16'h5A5A);

      // single A read
      repeat (2) tick();
      clear_logs();
      fixed_rdata = 16'h1234;
      a_bus.read = 1; a_bus.address = 16'h0040;
      tick();
      tick();
      chk1("a_read_strobe", pm_bus.read, 1'b1);
      chkw("a_read_addr", pm_bus.address, 16'h0040);
      wait_resps("a_read", 1, 20);
      chki("a_read_port", resp_port[0], 1);
      chkw("a_read_rdata", resp_data[0], 16'h1234);
      repeat (3) tick();
      chki("a_read_single", resp_port.size(), 1);

      // tie: B write wins over A read
      clear_logs();
      a_bus.read = 1; a_bus.address = 16'h0044;
      b_bus.write = 1; b_bus.address = 16'h0100; b_bus.wdata = 16'hBEEF; b_bus.wmask = 2'b01;
      tick();
      chk1("tie_b_write", pm_bus.write, 1'b1);
      chkw("tie_b_wmask", W'(pm_bus.wmask), W'(2'b01));
      chkw("tie_b_addr", pm_bus.address, 16'h0100);
      chkw("tie_b_wdata", pm_bus.wdata, 16'hBEEF);
      wait_resps("tie", 2, 30);
      exp_q = '{2, 1};
      chk_grants("tie");

      // both held continuously
      reset = 1;
      tick();
      tick();
      reset = 0;
      clear_logs();
      lat = 1; mode = 1;
      a_bus.read = 1; a_bus.write = 0; a_bus.address = 16'h0080;
      b_bus.read = 1; b_bus.write = 0; b_bus.address = 16'h0180;
      for (int k = 0; k < 40 && grants.size() < 6; k++) tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_q = '{1, 2, 1, 2, 1, 2};
`else
      exp_q = '{2, 2, 2, 2, 1, 2};
`endif
      chk_grants("hold");
      mode = 0;
      a_bus.read = 0; b_bus.read = 0;
      repeat (6) tick();

      // B drops its request mid-transaction
      clear_logs();
      lat = 3;
      b_bus.read = 1; b_bus.address = 16'h0200;
      tick();
      b_bus.read = 0; b_bus.address = 16'hFFFF;
      tick();
      chkw("drop_b_addr", pm_bus.address, 16'h0200);
      wait_resps("drop_b", 1, 20);
      repeat (4) tick();
      chki("drop_b_once", resp_port.size(), 1);

      // reset during SERVE_A aborts without a response
      clear_logs();
      lat = 10;
      a_bus.read = 1; a_bus.address = 16'h0300;
      tick();
      tick();
      chk1("pre_abort_strobe", pm_bus.read, 1'b1);
      reset = 1; a_bus.read = 0;
      tick();
      chk1("abort_a_resp", a_bus.resp, 1'b0);
      chk1("abort_strobe", pm_bus.read, 1'b0);
      reset = 0;
      repeat (6) tick();
      chki("abort_no_resp", resp_port.size(), 0);

      // random traffic with stray memory responses while idle
      mode = 2; rand_lat = 1; stray_en = 1; use_fixed = 0;
      repeat (2000) tick();
      mode = 0;
      a_bus.read = 0; a_bus.write = 0; b_bus.read = 0; b_bus.write = 0;
      repeat (8) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
